// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: ID-stage decode, ID/EX control register and multi-cycle FPU
// occupancy tracking. EX loads, in priority order: hold on stall_in, bubble on
// flush, bubble on hazard or FPU wait, otherwise the decoded ID instruction.
// Optional feature: define CTRL_LOAD_USE_HAZARD_EN to enable load-use hazard
// detection; when undefined the hazard term is tied to zero.
module ctrl_pipe_unit #(
   parameter int unsigned FPU_LAT = 4,
   parameter int unsigned RA_W    = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_id,
   input  logic [6:0]      opcode_id,
   input  logic [6:0]      funct7_id,
   input  logic [RA_W-1:0] rd_id,
   input  logic [RA_W-1:0] rs1_id,
   input  logic [RA_W-1:0] rs2_id,
   input  logic            stall_in,
   input  logic            flush,
   output logic [10:0]     ctrl_ex,
   output logic            valid_ex,
   output logic [RA_W-1:0] rd_ex,
   output logic            stall_id,
   output logic            fpu_busy
);

   localparam logic [6:0] F7_FP_A = 7'b0011000;
   localparam logic [6:0] F7_FP_B = 7'b0011100;
   localparam logic [3:0] CNT_INIT = 4'(FPU_LAT - 1);

   typedef enum logic [0:0] {StIdle, StFpuWait} state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [10:0] ctrl_id;
   logic        multi_id;
   logic        hazard;
   logic        bubble;
   logic        fpu_start;

   // Combinational decode of the ID instruction, re-evaluated every cycle
   always_comb begin
      ctrl_id  = 11'b0;
      multi_id = 1'b0;
      case (opcode_id)
         7'b0010011,
         7'b0110111,
         7'b0111111: ctrl_id = 11'b10010001000;
         7'b0110011: ctrl_id = 11'b00010001000;
         7'b0000011: ctrl_id = 11'b11011000000;
         7'b0100011: ctrl_id = 11'b10000100000;
         7'b1100011: ctrl_id = 11'b00000011000;
         7'b0000111: ctrl_id = 11'b11101000000;
         7'b0100111: ctrl_id = 11'b10000100001;
         7'b1100111,
         7'b1101111: ctrl_id = 11'b00010011000;
         7'b1010011: begin
            if (funct7_id == F7_FP_A) begin
               ctrl_id = 11'b00010001110;
            end else if (funct7_id == F7_FP_B) begin
               ctrl_id = 11'b00100001100;
            end else begin
               ctrl_id  = 11'b00100001111;
               multi_id = 1'b1;
            end
         end
         default: ctrl_id = 11'b0;
      endcase
   end

`ifdef CTRL_LOAD_USE_HAZARD_EN
   logic [1:0] rw_ex;
   logic       match_rs1;
   logic       match_rs2;

   // Integer producers never forward x0; FP producers have no zero register
   assign rw_ex     = ctrl_ex[8:7];
   assign match_rs1 = (rd_ex == rs1_id) &&
                      ((rw_ex == 2'b01 && rd_ex != '0 && !ctrl_id[1]) ||
                       (rw_ex == 2'b10 && ctrl_id[1]));
   assign match_rs2 = (rd_ex == rs2_id) &&
                      ((rw_ex == 2'b01 && rd_ex != '0 && !ctrl_id[0]) ||
                       (rw_ex == 2'b10 && ctrl_id[0]));
   assign hazard    = valid_ex & ctrl_ex[6] & valid_id & (match_rs1 | match_rs2);
`else
   // Load-use ordering is the compiler's job in this build
   logic unused_rs;
   assign unused_rs = ^{rs1_id, rs2_id};
   assign hazard    = 1'b0;
`endif

   assign fpu_busy  = (state_q == StFpuWait);
   assign bubble    = hazard | fpu_busy;
   assign stall_id  = stall_in | hazard | fpu_busy;
   assign fpu_start = !stall_in && !flush && !bubble && valid_id && multi_id;

   // ID/EX control register: hold > flush > bubble > capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_ex  <= 11'b0;
         valid_ex <= 1'b0;
         rd_ex    <= '0;
      end else if (!stall_in) begin
         if (flush || bubble || !valid_id) begin
            ctrl_ex  <= 11'b0;
            valid_ex <= 1'b0;
            rd_ex    <= '0;
         end else begin
            ctrl_ex  <= ctrl_id;
            valid_ex <= 1'b1;
            rd_ex    <= rd_id;
         end
      end
   end

   // FPU occupancy FSM; flush does not touch it since the EX op is older
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
      end else if (!stall_in) begin
         case (state_q)
            StIdle: begin
               if (fpu_start && (FPU_LAT > 1)) begin
                  state_q <= StFpuWait;
                  cnt_q   <= CNT_INIT;
               end
            end
            StFpuWait: begin
               if (cnt_q == 4'd1) begin
                  state_q <= StIdle;
               end
               cnt_q <= cnt_q - 4'd1;
            end
            default: begin
               state_q <= StIdle;
               cnt_q   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: decode table, FPU wait, flush/stall
// priority, async reset mid-wait and load-use behaviour for either build.
module tb_ctrl_pipe_unit;

`ifdef CTRL_LOAD_USE_HAZARD_EN
   localparam bit LU_EN = 1'b1;
`else
   localparam bit LU_EN = 1'b0;
`endif

   localparam logic [6:0] OP_ADD = 7'b0110011;
   localparam logic [6:0] OP_FP  = 7'b1010011;
   localparam logic [10:0] C_ADD = 11'b00010001000;
   localparam logic [10:0] C_FPM = 11'b00100001111;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_id;
   logic [6:0]  opcode_id;
   logic [6:0]  funct7_id;
   logic [4:0]  rd_id, rs1_id, rs2_id;
   logic        stall_in;
   logic        flush;
   logic [10:0] ctrl_ex, ctrl_ex1;
   logic        valid_ex, valid_ex1;
   logic [4:0]  rd_ex, rd_ex1;
   logic        stall_id, stall_id1;
   logic        fpu_busy, fpu_busy1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ctrl_pipe_unit #(.FPU_LAT(4), .RA_W(5)) dut (
      .clk(clk), .rst(rst), .valid_id(valid_id), .opcode_id(opcode_id),
      .funct7_id(funct7_id), .rd_id(rd_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .stall_in(stall_in), .flush(flush), .ctrl_ex(ctrl_ex), .valid_ex(valid_ex),
      .rd_ex(rd_ex), .stall_id(stall_id), .fpu_busy(fpu_busy)
   );

   ctrl_pipe_unit #(.FPU_LAT(1), .RA_W(5)) dut1 (
      .clk(clk), .rst(rst), .valid_id(valid_id), .opcode_id(opcode_id),
      .funct7_id(funct7_id), .rd_id(rd_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .stall_in(stall_in), .flush(flush), .ctrl_ex(ctrl_ex1), .valid_ex(valid_ex1),
      .rd_ex(rd_ex1), .stall_id(stall_id1), .fpu_busy(fpu_busy1)
   );

   typedef struct {
      logic [6:0]  op;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic        valid;
      logic        stall;
      logic        flush;
      logic [10:0] ctrl;
      logic        vex;
      logic [4:0]  rdx;
   } vec_t;

   vec_t tbl [21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [6:0] op, input logic [6:0] f7, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic v,
                         input logic st, input logic fl);
      opcode_id = op;
      funct7_id = f7;
      rd_id     = rd;
      rs1_id    = rs1;
      rs2_id    = rs2;
      valid_id  = v;
      stall_in  = st;
      flush     = fl;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      set_in(7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc();
   endtask

   // Leaves the DUT one cycle into FPU_WAIT with the multi-cycle op in EX
   task automatic fpu_capture(input string tag);
      nop();
      set_in(OP_FP, 7'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      #1;
      chk({tag, " pre stall_id"}, 32'(stall_id), 32'd0);
      cyc();
      chk({tag, " fpu ctrl"}, 32'(ctrl_ex), 32'(C_FPM));
      chk({tag, " fpu busy"}, 32'(fpu_busy), 32'd1);
      set_in(OP_ADD, 7'd0, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic load_use(input string tag, input logic [6:0] lop, input logic [4:0] lrd,
                           input logic [6:0] dop, input logic [4:0] drs1,
                           input logic [4:0] drs2, input logic [10:0] dctrl,
                           input logic exp_stall);
      nop();
      set_in(lop, 7'd0, lrd, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      cyc();
      set_in(dop, 7'd0, 5'd6, drs1, drs2, 1'b1, 1'b0, 1'b0);
      #1;
      chk({tag, " stall_id"}, 32'(stall_id), 32'(exp_stall));
      cyc();
      if (exp_stall) begin
         chk({tag, " bubble"}, 32'(valid_ex), 32'd0);
         chk({tag, " stall released"}, 32'(stall_id), 32'd0);
         cyc();
      end
      chk({tag, " dep valid"}, 32'(valid_ex), 32'd1);
      chk({tag, " dep ctrl"}, 32'(ctrl_ex), 32'(dctrl));
      chk({tag, " dep rd"}, 32'(rd_ex), 32'd6);
   endtask

   initial begin
      logic [3:0] stall_pat;
      logic [3:0] busy_pat;
      logic [2:0] flush_pat;
      logic [2:0] fbusy_pat;

      tbl[0]  = '{7'b0110011, 7'b0000000, 5'd3,  1'b1, 1'b0, 1'b0, 11'b00010001000, 1'b1, 5'd3};
      tbl[1]  = '{7'b0010011, 7'b0000000, 5'd4,  1'b1, 1'b0, 1'b0, 11'b10010001000, 1'b1, 5'd4};
      tbl[2]  = '{7'b0110111, 7'b0000000, 5'd5,  1'b1, 1'b0, 1'b0, 11'b10010001000, 1'b1, 5'd5};
      tbl[3]  = '{7'b0111111, 7'b0000000, 5'd6,  1'b1, 1'b0, 1'b0, 11'b10010001000, 1'b1, 5'd6};
      tbl[4]  = '{7'b0000011, 7'b0000000, 5'd7,  1'b1, 1'b0, 1'b0, 11'b11011000000, 1'b1, 5'd7};
      tbl[5]  = '{7'b0100011, 7'b0000000, 5'd8,  1'b1, 1'b0, 1'b0, 11'b10000100000, 1'b1, 5'd8};
      tbl[6]  = '{7'b1100011, 7'b0000000, 5'd9,  1'b1, 1'b0, 1'b0, 11'b00000011000, 1'b1, 5'd9};
      tbl[7]  = '{7'b0000111, 7'b0000000, 5'd10, 1'b1, 1'b0, 1'b0, 11'b11101000000, 1'b1, 5'd10};
      tbl[8]  = '{7'b0100111, 7'b0000000, 5'd11, 1'b1, 1'b0, 1'b0, 11'b10000100001, 1'b1, 5'd11};
      tbl[9]  = '{7'b1100111, 7'b0000000, 5'd12, 1'b1, 1'b0, 1'b0, 11'b00010011000, 1'b1, 5'd12};
      tbl[10] = '{7'b1101111, 7'b0000000, 5'd13, 1'b1, 1'b0, 1'b0, 11'b00010011000, 1'b1, 5'd13};
      tbl[11] = '{7'b1010011, 7'b0011000, 5'd14, 1'b1, 1'b0, 1'b0, 11'b00010001110, 1'b1, 5'd14};
      tbl[12] = '{7'b1010011, 7'b0011100, 5'd15, 1'b1, 1'b0, 1'b0, 11'b00100001100, 1'b1, 5'd15};
      tbl[13] = '{7'b0000000, 7'b0000000, 5'd16, 1'b1, 1'b0, 1'b0, 11'b00000000000, 1'b1, 5'd16};
      tbl[14] = '{7'b1111111, 7'b0000000, 5'd17, 1'b1, 1'b0, 1'b0, 11'b00000000000, 1'b1, 5'd17};
      tbl[15] = '{7'b0110011, 7'b0000000, 5'd18, 1'b1, 1'b0, 1'b0, 11'b00010001000, 1'b1, 5'd18};
      tbl[16] = '{7'b0010011, 7'b0000000, 5'd19, 1'b1, 1'b1, 1'b0, 11'b00010001000, 1'b1, 5'd18};
      tbl[17] = '{7'b0010011, 7'b0000000, 5'd19, 1'b1, 1'b1, 1'b1, 11'b00010001000, 1'b1, 5'd18};
      tbl[18] = '{7'b0010011, 7'b0000000, 5'd19, 1'b1, 1'b0, 1'b1, 11'b00000000000, 1'b0, 5'd0};
      tbl[19] = '{7'b0110011, 7'b0000000, 5'd20, 1'b1, 1'b0, 1'b0, 11'b00010001000, 1'b1, 5'd20};
      tbl[20] = '{7'b0110011, 7'b0000000, 5'd21, 1'b0, 1'b0, 1'b0, 11'b00000000000, 1'b0, 5'd0};

      // Reset state
      rst = 1'b1;
      set_in(7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("rst ctrl_ex", 32'(ctrl_ex), 32'd0);
      chk("rst valid_ex", 32'(valid_ex), 32'd0);
      chk("rst rd_ex", 32'(rd_ex), 32'd0);
      chk("rst fpu_busy", 32'(fpu_busy), 32'd0);
      chk("rst stall_id", 32'(stall_id), 32'd0);
      stall_in = 1'b1;
      #1;
      chk("rst stall_id follows stall_in", 32'(stall_id), 32'd1);
      stall_in = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;

      // First instruction after reset
      set_in(OP_ADD, 7'd0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
      cyc();
      chk("first add ctrl", 32'(ctrl_ex), 32'(C_ADD));
      chk("first add valid", 32'(valid_ex), 32'd1);

      // Decode table plus stall/flush priority
      for (int i = 0; i < 21; i++) begin
         set_in(tbl[i].op, tbl[i].f7, tbl[i].rd, 5'd1, 5'd2, tbl[i].valid, tbl[i].stall,
                tbl[i].flush);
         #1;
         chk($sformatf("vec%0d stall_id", i), 32'(stall_id), 32'(tbl[i].stall));
         cyc();
         chk($sformatf("vec%0d ctrl", i), 32'(ctrl_ex), 32'(tbl[i].ctrl));
         chk($sformatf("vec%0d valid", i), 32'(valid_ex), 32'(tbl[i].vex));
         chk($sformatf("vec%0d rd", i), 32'(rd_ex), 32'(tbl[i].rdx));
         chk($sformatf("vec%0d busy", i), 32'(fpu_busy), 32'd0);
      end

      // FPU wait: exactly three stalled cycles with bubbles; FPU_LAT=1 never waits
      fpu_capture("wait");
      chk("lat1 busy", 32'(fpu_busy1), 32'd0);
      chk("lat1 stall_id", 32'(stall_id1), 32'd0);
      chk("lat1 ctrl", 32'(ctrl_ex1), 32'(C_FPM));
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("wait%0d stall_id", k), 32'(stall_id), 32'd1);
         cyc();
         chk($sformatf("wait%0d bubble", k), 32'(valid_ex), 32'd0);
         chk($sformatf("wait%0d busy", k), 32'(fpu_busy), 32'(k < 2));
         chk($sformatf("wait%0d lat1 busy", k), 32'(fpu_busy1), 32'd0);
      end
      chk("wait end stall_id", 32'(stall_id), 32'd0);
      cyc();
      chk("wait next ctrl", 32'(ctrl_ex), 32'(C_ADD));
      chk("wait next rd", 32'(rd_ex), 32'd8);

      // stall_in pulse mid-wait adds one cycle
      stall_pat = 4'b0010;
      busy_pat  = 4'b0111;
      fpu_capture("spulse");
      for (int k = 0; k < 4; k++) begin
         stall_in = stall_pat[k];
         cyc();
         chk($sformatf("spulse%0d busy", k), 32'(fpu_busy), 32'(busy_pat[k]));
         chk($sformatf("spulse%0d bubble", k), 32'(valid_ex), 32'd0);
      end
      cyc();
      chk("spulse next valid", 32'(valid_ex), 32'd1);

      // Flush during wait gives a bubble and the countdown continues
      flush_pat = 3'b001;
      fbusy_pat = 3'b011;
      fpu_capture("fwait");
      for (int k = 0; k < 3; k++) begin
         flush = flush_pat[k];
         cyc();
         chk($sformatf("fwait%0d busy", k), 32'(fpu_busy), 32'(fbusy_pat[k]));
         chk($sformatf("fwait%0d bubble", k), 32'(valid_ex), 32'd0);
      end
      cyc();
      chk("fwait next ctrl", 32'(ctrl_ex), 32'(C_ADD));

      // Async reset at cnt=2 clears immediately; capture resumes after release
      fpu_capture("arst");
      cyc();
      chk("arst busy before", 32'(fpu_busy), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("arst busy", 32'(fpu_busy), 32'd0);
      chk("arst ctrl", 32'(ctrl_ex), 32'd0);
      chk("arst valid", 32'(valid_ex), 32'd0);
      chk("arst stall_id", 32'(stall_id), 32'd0);
      cyc();
      chk("arst held busy", 32'(fpu_busy), 32'd0);
      rst = 1'b0;
      set_in(OP_ADD, 7'd0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      cyc();
      chk("arst capture valid", 32'(valid_ex), 32'd1);
      chk("arst capture rd", 32'(rd_ex), 32'd9);

      // Load-use: stalls only when detection is built in
      load_use("lu lw-add", 7'b0000011, 5'd5, OP_ADD, 5'd5, 5'd0, C_ADD, LU_EN);
      load_use("lu lw-x0", 7'b0000011, 5'd0, OP_ADD, 5'd0, 5'd0, C_ADD, 1'b0);
      load_use("lu flw-add", 7'b0000111, 5'd5, OP_ADD, 5'd5, 5'd0, C_ADD, 1'b0);
      load_use("lu flw-fsw", 7'b0000111, 5'd5, 7'b0100111, 5'd1, 5'd5, 11'b10000100001, LU_EN);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe_unit.md
CTRL_PIPE_UNIT -- requirements
Module: ctrl_pipe_unit

Interface
REQ-001 SHALL have parameter: FPU_LAT, 4, cycles a multi-cycle FPU op occupies EX (legal 1..15).
REQ-002 SHALL have parameter: RA_W, 5, register-address width.
REQ-003 SHALL have ports, in order:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_id  in  1  ID holds a real instruction.
- opcode_id  in  7  instruction opcode.
- funct7_id  in  7  instruction funct7.
- rd_id, rs1_id, rs2_id  in  RA_W each  destination and source register addresses.
- stall_in  in  1  downstream hold request.
- flush  in  1  kill the instruction in ID (taken branch or jump).
- ctrl_ex  out  11  registered control word.
- valid_ex  out  1  EX slot holds a real instruction.
- rd_ex  out  RA_W  registered destination.
- stall_id  out  1  hold PC and IF/ID.
- fpu_busy  out  1  multi-cycle FPU op in progress.

Function
REQ-004 Control word SHALL be {alusrc, memtoreg, regwrite[1:0], memread, memwrite, branch, aluop[1:0], rs1_fpu, rs2_fpu}, bit 10 down to bit 0. regwrite encoding: 01 = integer, 10 = FP.
REQ-005 Decode SHALL be combinational from opcode_id/funct7_id:
- 0000000 -> 0.
- 0010011, 0110111, 0111111 -> 10010001000.
- 0110011 -> 00010001000.
- 0000011 -> 11011000000.
- 0100011 -> 10000100000.
- 1100011 -> 00000011000.
- 0000111 -> 11101000000.
- 0100111 -> 10000100001.
- 1100111, 1101111 -> 00010011000.
- 1010011 with funct7 0011000 -> 00010001110.
- 1010011 with funct7 0011100 -> 00100001100.
- 1010011 with any other funct7 -> 00100001111.
- Any other opcode -> 0.
REQ-006 Multi-cycle op SHALL be opcode 1010011 with funct7 not in {0011000, 0011100}.
REQ-007 Update priority each cycle SHALL be: stall_in > flush > bubble > capture.
REQ-008 stall_in=1: all EX registers, FSM state and counter SHALL hold.
REQ-009 flush=1 (stall_in=0): EX SHALL load a bubble (valid_ex=0, ctrl_ex=0, rd_ex=0). The FSM and counter are unaffected, since the EX-resident FPU op is older than the flushed instruction.
REQ-010 Bubble condition SHALL be hazard=1 or state=FPU_WAIT; on bubble, EX SHALL load zeros.
REQ-011 Capture: EX SHALL load the decoded word, valid_id and rd_id when valid_id=1, and zeros when valid_id=0.
REQ-012 FSM states SHALL be IDLE and FPU_WAIT, with a 4-bit counter cnt.
- IDLE -> FPU_WAIT when a multi-cycle op is captured and FPU_LAT>1; cnt <= FPU_LAT-1.
- In FPU_WAIT, cnt SHALL decrement on each cycle with stall_in=0.
- When cnt=1 and decrementing, the FSM SHALL return to IDLE.
REQ-013 fpu_busy SHALL equal (state==FPU_WAIT).
REQ-014 stall_id SHALL equal stall_in | hazard | fpu_busy, combinationally.
REQ-015 With FPU_LAT=1, multi-cycle ops SHALL behave as single-cycle: no FPU_WAIT and no stall.
REQ-016 The decode of a stalled ID instruction SHALL be re-evaluated every cycle; no ID-side state is held.

Reset
REQ-017 While rst=1, asynchronously: ctrl_ex=0, valid_ex=0, rd_ex=0, state=IDLE, cnt=0, fpu_busy=0. stall_id then reflects stall_in only.
REQ-018 rst asserted during FPU_WAIT SHALL abort the wait immediately. The first rising edge after deassertion SHALL follow REQ-007.

Configuration
REQ-019 Macro CTRL_LOAD_USE_HAZARD_EN controls load-use detection:
- Defined: hazard = valid_ex & ctrl_ex[6] & valid_id & match, where:
  - match for rs1: (ctrl_ex regwrite=01, rd_ex!=0, rs1_fpu=0, rd_ex==rs1_id) or (regwrite=10, rs1_fpu=1, rd_ex==rs1_id).
  - match for rs2: same rule using rs2_id and rs2_fpu.
  - Result: exactly one bubble per load-use pair.
- Undefined: hazard SHALL be the constant 0; the load-use dependence is resolved by software.

Verification
REQ-020 Reset/decode: rst pulse, then valid_id with opcode 0110011 -> next edge ctrl_ex=00010001000, valid_ex=1; all outputs 0 during rst.
REQ-021 FPU wait: FPU_LAT=4, opcode 1010011, funct7 0000000 captured -> fpu_busy=1 and stall_id=1 for exactly 3 cycles, with 3 bubbles in EX; a stall_in pulse mid-wait extends the wait by 1 cycle.
REQ-022 Load-use (EN defined): lw with rd=5 in EX, add with rs1=5 in ID -> stall_id=1 for 1 cycle, one bubble, add captured next. Same case with rd=0 -> no stall. flw rd=5 followed by integer rs1=5 -> no stall.
REQ-023 Load-use (EN undefined): same lw/add sequence -> no stall, add captured immediately.
REQ-024 Flush priority: flush=1 and stall_in=1 together -> EX holds. flush alone during FPU_WAIT -> bubble, cnt keeps counting down.
REQ-025 Async reset mid-wait: rst asserted at cnt=2 -> fpu_busy=0 without waiting for a clock edge; the next instruction is captured on the first edge after release.
